// File: rtl/fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fetch_unit
// Brief   : Instruction-fetch sequencer. Owns the PC, slices the fetched word
//           for the decoder, resolves branches and counts RUN cycles.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module fetch_unit #(
    parameter int              PC_W       = 10,
    parameter int              INSTR_W    = 9,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter logic [3:0]      HALT_OP    = 4'hF,
    parameter int              CNT_W      = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 stall,
    input  logic                 CTRL_branch_abs,
    input  logic                 CTRL_branch_rel_z,
    input  logic                 CTRL_branch_rel_nz,
    input  logic                 zero,
    input  logic [PC_W-1:0]      rel_offset,
    input  logic [PC_W-1:0]      abs_target,
    input  logic [INSTR_W-1:0]   instr,
    output logic [PC_W-1:0]      PC,
    output logic [3:0]           opcode,
    output logic                 fcode,
    output logic [INSTR_W-6:0]   operand,
    output logic                 DONE,
    output logic [CNT_W-1:0]     cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [PC_W-1:0]  c_PC_ONE  = PC_W'(1);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             w_rel_taken;
    logic [PC_W-1:0]  w_pc_seq;
    logic [PC_W-1:0]  w_pc_rel;
    logic [CNT_W-1:0] w_cnt_inc;

    // Decoder sees raw slices in every state; it qualifies them with DONE.
    assign opcode  = instr[INSTR_W-1 -: 4];
    assign fcode   = instr[INSTR_W-5];
    assign operand = instr[INSTR_W-6:0];

    assign w_rel_taken = (CTRL_branch_rel_z  &&  zero) ||
                         (CTRL_branch_rel_nz && !zero);
    assign w_pc_seq    = pc_q + c_PC_ONE;
    assign w_pc_rel    = pc_q + rel_offset;
    assign w_cnt_inc   = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (START) begin
                    state_d = ST_RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // The halting cycle is still counted, so the increment is unconditional here.
                cnt_d = w_cnt_inc;
                if (!stall) begin
                    if (opcode == HALT_OP) begin
                        state_d = ST_HALT;
                    end else if (CTRL_branch_abs) begin
                        pc_d = abs_target;
                    end else if (w_rel_taken) begin
                        pc_d = w_pc_rel;
                    end else begin
                        pc_d = w_pc_seq;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase

        done_d = (state_d != ST_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign PC          = pc_q;
    assign DONE        = done_q;
    assign cycle_count = cnt_q;

endmodule
`default_nettype wire
